// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU.
// One transaction in flight; a watchdog forces an error response on a hung bus.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    output logic        ifu_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic             wen_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;

    logic        idle;
    logic        gnt_ifu;
    logic        gnt_lsu;
    logic        timeout;
    logic        fire;
    logic        done;
    logic [31:0] rsp_data;
    logic        rsp_err;

    // last_q = 1 means the LSU was granted last, so the IFU is favoured.
    always_comb begin
        idle     = (state_q == IDLE);
        gnt_ifu  = idle & ~rst & ifu_valid & (~lsu_valid | last_q);
        gnt_lsu  = idle & ~rst & lsu_valid & (~ifu_valid | ~last_q);
        timeout  = ~idle & (cnt_q == CNT_W'(TIMEOUT));
        fire     = mem_rvalid & ((state_q == RESP) |
                                 ((state_q == REQ) & mem_ready));
        done     = ~rst & (timeout | fire);
        rsp_data = timeout ? 32'h0 : mem_rdata;
        rsp_err  = timeout | mem_err;
    end

    assign ifu_ready  = gnt_ifu;
    assign lsu_ready  = gnt_lsu;
    assign ifu_rvalid = done & ~owner_q;
    assign lsu_rvalid = done & owner_q;
    assign ifu_rdata  = ifu_rvalid ? rsp_data : 32'h0;
    assign lsu_rdata  = lsu_rvalid ? rsp_data : 32'h0;
    assign ifu_err    = ifu_rvalid & rsp_err;
    assign lsu_err    = lsu_rvalid & rsp_err;

    assign mem_valid = (state_q == REQ);
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = ~idle;
    assign owner     = owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_ifu | gnt_lsu) begin
                        addr_q  <= gnt_lsu ? lsu_addr : ifu_addr;
                        wen_q   <= gnt_lsu & lsu_wen;
                        wdata_q <= gnt_lsu ? lsu_wdata : 32'h0;
                        wmask_q <= gnt_lsu ? lsu_wmask : 4'h0;
                        owner_q <= gnt_lsu;
                        last_q  <= gnt_lsu;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout) begin
                        state_q <= IDLE;
                    end else if (mem_ready) begin
                        state_q <= mem_rvalid ? IDLE : RESP;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout | mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a scripted memory
// responder, and a monitor that checks every response pulse against a queue.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_valid, ifu_ready, ifu_rvalid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_valid, lsu_ready, lsu_wen, lsu_rvalid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy, owner;

    mem_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          who;
        logic [31:0] data;
        bit          err;
        int          at;
    } exp_t;
    exp_t sbq[$];

    // Responder control, written only by the main process.
    int          mode    = 0;
    int          waits   = 0;
    logic [31:0] key     = 32'h0;
    bit          err_val = 1'b0;
    int          inj_req = 0;
    int          inj_ack = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Memory model: mode 0 normal, 1 ready+rvalid together,
    // 2 never ready, 3 ready but never responds.
    initial begin
        int wc;
        bit pend;
        logic [31:0] pdata;
        wc = 0; pend = 0; pdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
            if (rst) begin
                wc = 0; pend = 0;
            end else if (inj_req != inj_ack) begin
                mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
                inj_ack++;
            end else if (pend) begin
                mem_rvalid = 1; mem_rdata = pdata; mem_err = err_val;
                pend = 0;
            end else if (mem_valid && mode != 2) begin
                if (wc < waits) begin
                    wc++;
                end else begin
                    wc = 0;
                    mem_ready = 1;
                    if (mode == 1) begin
                        mem_rvalid = 1; mem_rdata = mem_addr ^ key;
                        mem_err = err_val;
                    end else if (mode == 0) begin
                        pend = 1; pdata = mem_addr ^ key;
                    end
                end
            end
        end
    end

    // Monitor: every response pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifu_rvalid && lsu_rvalid) begin
                chk("dual_rvalid", 32'd1, 32'd0);
            end else if (ifu_rvalid || lsu_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", {31'd0, lsu_rvalid}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_who", {31'd0, lsu_rvalid}, {31'd0, e.who});
                    chk("rsp_data", lsu_rvalid ? lsu_rdata : ifu_rdata, e.data);
                    chk("rsp_err", {31'd0, lsu_rvalid ? lsu_err : ifu_err},
                        {31'd0, e.err});
                    chk("rsp_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic push(input bit who, input logic [31:0] a, input int at,
                        input bit to);
        exp_t e;
        e.who  = who;
        e.data = to ? 32'h0 : (a ^ key);
        e.err  = to ? 1'b1 : err_val;
        e.at   = at;
        sbq.push_back(e);
    endtask

    task automatic do_req(input bit who, input logic [31:0] a, input bit we,
                          input logic [31:0] wd, input logic [3:0] wm,
                          input int lat, input bit to, output int acc);
        bit ok;
        @(posedge clk); #1;
        if (who) begin
            lsu_valid = 1; lsu_addr = a; lsu_wen = we;
            lsu_wdata = wd; lsu_wmask = wm;
        end else begin
            ifu_valid = 1; ifu_addr = a;
        end
        ok = 0;
        acc = -1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (who ? lsu_ready : ifu_ready) ok = 1;
        end
        chk("accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            acc = cyc;
            push(who, a, acc + lat, to);
        end
        @(posedge clk); #1;
        ifu_valid = 0; lsu_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        chk("idle_reached", {31'd0, ok}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Hold both valids high and collect n grants.
    task automatic collect(input int n, input int lat, input bit both,
                           output bit gw[8], output int gc[8]);
        int k;
        k = 0;
        for (int i = 0; i < 200 && k < n; i++) begin
            @(negedge clk);
            if (ifu_ready && lsu_ready) chk("both_ready", 32'd1, 32'd0);
            if (ifu_ready || lsu_ready) begin
                gw[k] = lsu_ready;
                gc[k] = cyc;
                push(lsu_ready, lsu_ready ? lsu_addr : ifu_addr, cyc + lat, 0);
                k++;
            end
        end
        chk("grant_count", k, n);
        @(posedge clk); #1;
        ifu_valid = 0; lsu_valid = 0;
        if (!both) gw[0] = 0;
    endtask

    initial begin
        int  acc;
        bit  gw[8];
        int  gc[8];
        rst = 1;
        ifu_valid = 0; ifu_addr = 0;
        lsu_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_rvalid", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // IFU fetch, zero-wait memory: 0x30000000 ^ key = 0xDEADBEEF
        mode = 0; waits = 0; key = 32'hEEAD_BEEF;
        do_req(0, 32'h3000_0000, 0, 0, 0, 2, 0, acc);
        @(negedge clk);
        chk("t1_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h3000_0000);
        chk("t1_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("t1_owner", {31'd0, owner}, 32'd0);
        wait_idle();

        // LSU store with three wait cycles; fields stable across the waits.
        key = 32'h0000_1111; waits = 3;
        do_req(1, 32'h8000_0010, 1, 32'h1234_5678, 4'b0011, 5, 0, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_mem_valid", {31'd0, mem_valid}, 32'd1);
            chk("st_mem_addr", mem_addr, 32'h8000_0010);
            chk("st_mem_wen", {31'd0, mem_wen}, 32'd1);
            chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
            chk("st_mem_wmask", {28'd0, mem_wmask}, 32'h3);
        end
        wait_idle();

        // Contended: six grants alternate starting with the IFU, every 3 cycles.
        waits = 0; key = 32'h5A5A_0000;
        @(posedge clk); #1;
        ifu_valid = 1; ifu_addr = 32'h0000_1000;
        lsu_valid = 1; lsu_addr = 32'h0000_2000; lsu_wen = 0; lsu_wmask = 4'hF;
        collect(6, 2, 1, gw, gc);
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant", {31'd0, gw[k]}, k % 2);
            if (k > 0) chk("rr_spacing", gc[k] - gc[k-1], 3);
        end
        wait_idle();

        // Ready and response in the first REQ cycle; next accept one cycle later.
        mode = 1; key = 32'h0F0F_0F0F; err_val = 1;
        @(posedge clk); #1;
        ifu_valid = 1; ifu_addr = 32'h0000_4444;
        collect(2, 1, 0, gw, gc);
        chk("combo_spacing", gc[1] - gc[0], 2);
        wait_idle();
        err_val = 0;

        // Watchdog: memory never ready, error pulse at accept + TO + 1.
        mode = 2;
        do_req(1, 32'h9000_0000, 0, 0, 4'hF, TO + 1, 1, acc);
        wait_idle();
        inj_req++;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (mem_rvalid) seen = 1;
            end
            chk("late_seen", {31'd0, seen}, 32'd1);
            chk("late_no_pulse", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
        end
        wait_idle();

        // Reset while waiting in RESP aborts the transaction silently.
        mode = 3;
        sbq.push_back('{who: 0, data: 32'h0, err: 0, at: -1});
        do_req(0, 32'h7000_0000, 0, 0, 0, 0, 0, acc);
        void'(sbq.pop_back());
        void'(sbq.pop_back());
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        mode = 0; key = 32'h1357_9BDF;
        do_req(0, 32'h3000_0040, 0, 0, 0, 2, 0, acc);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
